// File: rtl/ir_nec_tx.sv
// NEC IR transmitter: serialises {addr,cmd} codes into NEC frames and repeat frames,
// producing the mark/space envelope and the carrier-modulated LED drive.
module ir_nec_tx #(
    parameter int UNIT_CYCLES  = 15188,
    parameter int CARRIER_DIV  = 711,
    parameter int CARRIER_HIGH = 237,
    parameter int FRAME_UNITS  = 192
) (
    input  logic        clk27,
    input  logic        reset_n,
    input  logic [15:0] tx_code,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic        repeat_en,
    output logic        ir_env,
    output logic        ir_tx,
    output logic        busy,
    output logic [7:0]  tx_cnt
);
    localparam int UNIT_W  = $clog2(UNIT_CYCLES + 1);
    localparam int PHASE_W = $clog2(CARRIER_DIV + 1);
    localparam int FRAME_W = $clog2(FRAME_UNITS + 1);

    typedef enum logic [3:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK,
        GAP,
        REP_MARK,
        REP_SPACE,
        REP_STOP
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [UNIT_W-1:0]  unit_cnt;
    logic [4:0]         seg_units;
    logic [FRAME_W-1:0] frame_cnt;
    logic [31:0]        shift_word;
    logic [4:0]         bit_idx;
    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] phase_nx;
    logic               unit_tick;
    logic               seg_done;
    logic               state_change;
    logic               accept;
    logic               shift_adv;
    logic               frame_restart;
    logic               cnt_inc;
    logic               mark_nx;

    // Length of each timed state in NEC units; IDLE and GAP are not length-timed.
    function automatic logic [4:0] seg_len(input state_t s, input logic bit_val);
        case (s)
            LEAD_MARK, REP_MARK:           seg_len = 5'd16;
            LEAD_SPACE:                    seg_len = 5'd8;
            REP_SPACE:                     seg_len = 5'd4;
            BIT_SPACE:                     seg_len = bit_val ? 5'd3 : 5'd1;
            BIT_MARK, STOP_MARK, REP_STOP: seg_len = 5'd1;
            default:                       seg_len = 5'd0;
        endcase
    endfunction

    function automatic logic is_mark(input state_t s);
        is_mark = (s == LEAD_MARK) || (s == BIT_MARK) || (s == STOP_MARK) ||
                  (s == REP_MARK)  || (s == REP_STOP);
    endfunction

    assign unit_tick    = (unit_cnt == UNIT_W'(UNIT_CYCLES - 1));
    assign seg_done     = unit_tick && (seg_units == seg_len(state, shift_word[0]) - 5'd1);
    assign state_change = (state_nx != state);

    always_comb begin
        state_nx      = state;
        accept        = 1'b0;
        shift_adv     = 1'b0;
        frame_restart = 1'b0;
        cnt_inc       = 1'b0;
        case (state)
            IDLE: begin
                if (tx_valid) begin
                    state_nx      = LEAD_MARK;
                    accept        = 1'b1;
                    frame_restart = 1'b1;
                end
            end
            LEAD_MARK:  if (seg_done) state_nx = LEAD_SPACE;
            LEAD_SPACE: if (seg_done) state_nx = BIT_MARK;
            BIT_MARK:   if (seg_done) state_nx = BIT_SPACE;
            BIT_SPACE: begin
                if (seg_done) begin
                    shift_adv = 1'b1;
                    state_nx  = (bit_idx == 5'd31) ? STOP_MARK : BIT_MARK;
                end
            end
            STOP_MARK: begin
                if (seg_done) begin
                    state_nx = GAP;
                    cnt_inc  = 1'b1;
                end
            end
            GAP: begin
                // repeat_en matters only on this exit cycle
                if (frame_cnt == FRAME_W'(FRAME_UNITS)) begin
                    if (repeat_en) begin
                        state_nx      = REP_MARK;
                        frame_restart = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            REP_MARK:  if (seg_done) state_nx = REP_SPACE;
            REP_SPACE: if (seg_done) state_nx = REP_STOP;
            REP_STOP: begin
                if (seg_done) begin
                    state_nx = GAP;
                    cnt_inc  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Carrier phase restarts on every space-to-mark edge so each mark begins high.
    always_comb begin
        mark_nx = is_mark(state_nx);
        if (mark_nx && !ir_env) begin
            phase_nx = '0;
        end else if (phase == PHASE_W'(CARRIER_DIV - 1)) begin
            phase_nx = '0;
        end else begin
            phase_nx = phase + 1'b1;
        end
    end

    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            unit_cnt  <= '0;
            seg_units <= '0;
            frame_cnt <= '0;
        end else begin
            if (state == IDLE || state_change || unit_tick) begin
                unit_cnt <= '0;
            end else begin
                unit_cnt <= unit_cnt + 1'b1;
            end

            if (state_change) begin
                seg_units <= '0;
            end else if (unit_tick) begin
                seg_units <= seg_units + 5'd1;
            end

            if (frame_restart) begin
                frame_cnt <= '0;
            end else if (unit_tick && frame_cnt != FRAME_W'(FRAME_UNITS)) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // Word goes out LSB first: addr, ~addr, cmd, ~cmd.
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            shift_word <= '0;
            bit_idx    <= '0;
            tx_cnt     <= '0;
        end else begin
            if (accept) begin
                shift_word <= {~tx_code[7:0], tx_code[7:0], ~tx_code[15:8], tx_code[15:8]};
                bit_idx    <= '0;
            end else if (shift_adv) begin
                shift_word <= {1'b0, shift_word[31:1]};
                bit_idx    <= bit_idx + 5'd1;
            end

            if (cnt_inc) begin
                tx_cnt <= tx_cnt + 8'd1;
            end
        end
    end

    // Registered outputs keep the LED drive free of state-decode glitches.
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            phase  <= '0;
            ir_env <= 1'b0;
            ir_tx  <= 1'b0;
        end else begin
            phase  <= phase_nx;
            ir_env <= mark_nx;
            ir_tx  <= mark_nx && (phase_nx < PHASE_W'(CARRIER_HIGH));
        end
    end

    assign tx_ready = (state == IDLE);
    assign busy     = ~tx_ready;

endmodule

// File: tb/tb_ir_nec_tx.sv
// Bench for ir_nec_tx: a reference model turns each request into expected envelope
// segments, frame-count events and ready times; a monitor measures the DUT and compares.
module tb_ir_nec_tx;
    localparam int U    = 12;
    localparam int DIV  = 7;
    localparam int HIGH = 3;
    localparam int FU   = 192;
    localparam int P    = FU * U + 1;

    logic        clk27 = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] tx_code = 16'h0000;
    logic        tx_valid = 1'b0;
    logic        repeat_en = 1'b0;
    logic        tx_ready;
    logic        ir_env;
    logic        ir_tx;
    logic        busy;
    logic [7:0]  tx_cnt;

    ir_nec_tx #(
        .UNIT_CYCLES (U),
        .CARRIER_DIV (DIV),
        .CARRIER_HIGH(HIGH),
        .FRAME_UNITS (FU)
    ) dut (
        .clk27    (clk27),
        .reset_n  (reset_n),
        .tx_code  (tx_code),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .repeat_en(repeat_en),
        .ir_env   (ir_env),
        .ir_tx    (ir_tx),
        .busy     (busy),
        .tx_cnt   (tx_cnt)
    );

    always #5 clk27 = ~clk27;

    int cyc = 0;
    always @(posedge clk27) cyc <= cyc + 1;

    typedef struct {
        logic lvl;
        int   len;
    } seg_t;

    seg_t seg_q[$];
    int   cnt_val_q[$];
    int   cnt_time_q[$];
    int   rdy_q[$];

    int total = 0;
    int bad = 0;
    int model_cnt = 0;
    int pending_start = 0;
    int rearm_req = 0;
    bit mon_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name, input int act);
        total++;
        bad++;
        $display("FAIL %s: got %0d with nothing expected (cycle %0d)", name, act, cyc);
    endtask

    function automatic void push_seg(input logic lvl, input int len);
        seg_t s;
        s.lvl = lvl;
        s.len = len;
        seg_q.push_back(s);
    endfunction

    // Monitor: run-length measures ir_env, checks carrier shape inside each run,
    // and watches tx_cnt changes and tx_ready returns.
    int         run_len = 0;
    int         rearm_seen = 0;
    logic       cur_lvl = 1'b0;
    bit         car_ok = 1'b1;
    logic       prev_rdy = 1'b1;
    logic [7:0] prev_cnt = 8'd0;
    logic       exp_tx;
    seg_t       mon_e;

    always @(negedge clk27) begin
        if (mon_en) begin
            if (rearm_seen != rearm_req) begin
                rearm_seen = rearm_req;
                cur_lvl    = 1'b0;
                run_len    = 0;
                car_ok     = 1'b1;
                prev_rdy   = tx_ready;
                prev_cnt   = tx_cnt;
            end
            if (ir_env === cur_lvl) begin
                run_len++;
            end else begin
                if (seg_q.size() == 0) begin
                    unexpected("segment", run_len);
                end else begin
                    mon_e = seg_q.pop_front();
                    check("segment_level", int'(cur_lvl), int'(mon_e.lvl));
                    check("segment_length", run_len, mon_e.len);
                end
                check("carrier_shape", int'(car_ok), 1);
                cur_lvl = ir_env;
                run_len = 1;
                car_ok  = 1'b1;
            end
            exp_tx = ir_env && (((run_len - 1) % DIV) < HIGH);
            if (ir_tx !== exp_tx) car_ok = 1'b0;

            if (tx_ready && !prev_rdy) begin
                if (rdy_q.size() == 0) unexpected("ready_return", cyc);
                else check("ready_return_cycle", cyc, rdy_q.pop_front());
                check("busy_when_ready", int'(busy), 0);
            end
            prev_rdy = tx_ready;

            if (tx_cnt != prev_cnt) begin
                if (cnt_val_q.size() == 0) begin
                    unexpected("tx_cnt_change", int'(tx_cnt));
                end else begin
                    check("tx_cnt_value", int'(tx_cnt), cnt_val_q.pop_front());
                    check("tx_cnt_cycle", cyc, cnt_time_q.pop_front());
                end
            end
            prev_cnt = tx_cnt;
        end
    end

    // Issue one code (with reps repeat frames) and push everything the model predicts.
    task automatic send(input logic [15:0] code, input int reps, input bit beef,
                        input bit toggle, input int abort_bit);
        int          m;
        int          used;
        int          start;
        int          t;
        int          wait_n;
        logic [31:0] w;

        wait_n = 0;
        while (!tx_ready && wait_n < 3 * P) begin
            @(negedge clk27);
            wait_n++;
        end
        check("ready_before_send", int'(tx_ready), 1);
        repeat ($urandom_range(0, 3)) @(negedge clk27);
        tx_code   = code;
        tx_valid  = 1'b1;
        repeat_en = (reps > 0);
        @(posedge clk27);
        #1;
        m        = cyc;
        tx_valid = 1'b0;
        tx_code  = 16'($urandom);
        check("busy_after_accept", int'(busy), 1);

        w = {~code[7:0], code[7:0], ~code[15:8], code[15:8]};
        push_seg(1'b0, m - pending_start);
        push_seg(1'b1, 16 * U);
        push_seg(1'b0, 8 * U);
        used = 24;
        for (int i = 0; i < 32; i++) begin
            push_seg(1'b1, U);
            push_seg(1'b0, w[i] ? 3 * U : U);
            used += w[i] ? 4 : 2;
        end
        push_seg(1'b1, U);
        used += 1;
        start = m;
        model_cnt = (model_cnt + 1) % 256;
        cnt_val_q.push_back(model_cnt);
        cnt_time_q.push_back(start + used * U);
        for (int r = 0; r < reps; r++) begin
            push_seg(1'b0, P - used * U);
            start += P;
            push_seg(1'b1, 16 * U);
            push_seg(1'b0, 4 * U);
            push_seg(1'b1, U);
            used = 21;
            model_cnt = (model_cnt + 1) % 256;
            cnt_val_q.push_back(model_cnt);
            cnt_time_q.push_back(start + used * U);
        end
        pending_start = start + used * U;
        rdy_q.push_back(start + P);

        if (abort_bit >= 0) begin
            t = m + 24 * U;
            for (int j = 0; j < abort_bit; j++) t += (w[j] ? 4 : 2) * U;
            t += 3;
            while (cyc < t) @(negedge clk27);
            mon_en  = 1'b0;
            reset_n = 1'b0;
            #1;
            check("abort_ir_env", int'(ir_env), 0);
            check("abort_ir_tx", int'(ir_tx), 0);
            check("abort_tx_cnt", int'(tx_cnt), 0);
            check("abort_tx_ready", int'(tx_ready), 1);
            seg_q.delete();
            cnt_val_q.delete();
            cnt_time_q.delete();
            rdy_q.delete();
            model_cnt = 0;
            repeat (3) @(negedge clk27);
            reset_n = 1'b1;
            @(posedge clk27);
            #1;
            rearm_req++;
            mon_en = 1'b1;
            pending_start = cyc;
            @(negedge clk27);
            return;
        end

        if (toggle && reps == 0) begin
            for (int k = 0; k < 40; k++) begin
                @(negedge clk27);
                repeat_en = 1'($urandom_range(0, 1));
            end
            repeat_en = 1'b0;
        end
        if (beef) begin
            t = m + int'($urandom_range(20, 100 * U));
            while (cyc < t) @(negedge clk27);
            tx_code  = 16'hBEEF;
            tx_valid = 1'b1;
            check("ready_low_midframe", int'(tx_ready), 0);
            @(negedge clk27);
            tx_valid = 1'b0;
        end
        if (reps > 0) begin
            while (cyc < start + 5) @(negedge clk27);
            repeat_en = 1'b0;
        end
        while (cyc < start + P) @(negedge clk27);
    endtask

    initial begin
        repeat (3) @(posedge clk27);
        #1;
        check("reset_tx_ready", int'(tx_ready), 1);
        check("reset_ir_env", int'(ir_env), 0);
        check("reset_ir_tx", int'(ir_tx), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_tx_cnt", int'(tx_cnt), 0);
        @(negedge clk27);
        reset_n = 1'b1;
        @(posedge clk27);
        #1;
        rearm_req++;
        mon_en = 1'b1;
        pending_start = cyc;
        @(negedge clk27);

        send(16'h0045, 0, 1'b0, 1'b0, -1);
        send(16'h0045, 3, 1'b0, 1'b0, -1);
        for (int k = 0; k < 4; k++) begin
            send(16'($urandom), int'($urandom_range(0, 2)), k[0], 1'b1, -1);
        end
        send(16'($urandom), 0, 1'b0, 1'b0, 10);
        send(16'h1234, 0, 1'b0, 1'b0, -1);
        send(16'hA55A, 1, 1'b1, 1'b0, -1);

        repeat (4) @(negedge clk27);
        check("leftover_segments", seg_q.size(), 0);
        check("leftover_cnt_events", cnt_val_q.size(), 0);
        check("leftover_ready_events", rdy_q.size(), 0);
        check("final_tx_cnt", int'(tx_cnt), model_cnt);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
